ns_gnrl_rsp_router: RTL

//   Return path paired with the round-robin masked arbiter. Records the one-hot grant
//   of every accepted command into an in-order index FIFO. Routes each returning

---
 rtl/ns_gnrl_rsp_router.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ns_gnrl_rsp_router.sv
// Response router: in-order index FIFO of accepted grants steering responses back to their owners.
// Optional response timeout built only when NS_RSP_ROUTER_TMO_EN is defined.
module ns_gnrl_rsp_router #(
  parameter int unsigned PORT_NUM   = 8,
  parameter int unsigned OSTD_DEPTH = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TMO_CYC    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUM-1:0]           grt_vec,
  input  logic                          grt_acc,
  output logic                          ostd_full,
  output logic                          ostd_empty,
  output logic [$clog2(OSTD_DEPTH):0]   ostd_cnt,
  input  logic                          rsp_vld,
  input  logic [DATA_W-1:0]             rsp_dat,
  output logic                          rsp_rdy,
  output logic [PORT_NUM-1:0]           rsp_vld_vec,
  output logic [DATA_W-1:0]             rsp_dat_o,
  input  logic [PORT_NUM-1:0]           rsp_rdy_vec,
  output logic                          proto_err,
  output logic                          tmo_err
);

  localparam int unsigned IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned PTR_W = $clog2(OSTD_DEPTH);
  localparam int unsigned CNT_W = $clog2(OSTD_DEPTH) + 1;

  logic [IDX_W-1:0] fifo [OSTD_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic             perr_q;

  logic [IDX_W-1:0] grt_idx;
  logic             grt_found;
  logic             grt_multi;
  logic             push_try;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] hidx;

  // Lowest set bit wins when the grant is not one-hot.
  always_comb begin
    grt_idx   = '0;
    grt_found = 1'b0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (grt_vec[i] && !grt_found) begin
        grt_idx   = IDX_W'(i);
        grt_found = 1'b1;
      end
    end
  end

  assign grt_multi  = |(grt_vec & (grt_vec - PORT_NUM'(1)));
  assign ostd_full  = (cnt == CNT_W'(OSTD_DEPTH));
  assign ostd_empty = (cnt == '0);
  assign ostd_cnt   = cnt;

  assign push_try = grt_acc & (|grt_vec);
  assign push     = push_try & ~ostd_full;

  assign hidx        = fifo[rptr];
  assign rsp_rdy     = ~ostd_empty & rsp_rdy_vec[hidx];
  assign rsp_vld_vec = (rsp_vld & ~ostd_empty) ? (PORT_NUM'(1) << hidx) : '0;
  assign rsp_dat_o   = rsp_dat;
  assign pop         = rsp_vld & rsp_rdy;
  assign proto_err   = perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      perr_q <= 1'b0;
      for (int unsigned i = 0; i < OSTD_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= grt_idx;
        wptr       <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if ((push & grt_multi) | (push_try & ostd_full) | (rsp_vld & ostd_empty))
        perr_q <= 1'b1;
    end
  end

`ifdef NS_RSP_ROUTER_TMO_EN
  localparam int unsigned TMO_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (ostd_empty || pop)
        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (!ostd_empty && !pop && (tmo_cnt == TMO_MAX))
        tmo_q <= 1'b1;
    end
  end

  assign tmo_err = tmo_q;
`else
  assign tmo_err = 1'b0;
`endif

endmodule
